// File: rtl/m68k_reg_responder.sv
// m68k_reg_responder: 68k bus slave with a 16 x 16-bit register window.
// Decodes a selected bus cycle, waits a fixed number of clocks, then
// answers with nDTACK. REG[0..14] are byte-lane writable; REG[15] is a
// read-only count of acknowledged cycles.
module m68k_reg_responder #(
  parameter logic [23:0] BASE_ADDR   = 24'h3C0000,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        CLK_68KCLK,
  input  logic        nRESET,
  input  logic [23:1] M68K_ADDR,
  input  logic [15:0] M68K_DATA_IN,
  output logic [15:0] M68K_DATA_OUT,
  output logic        DATA_OE,
  input  logic        nAS,
  input  logic        nUDS,
  input  logic        nLDS,
  input  logic        M68K_RW,
  output logic        nDTACK
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_IGNORE,
    ST_WAIT,
    ST_ACK
  } state_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);
  localparam logic [3:0] CNT_IDX   = 4'd15;

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  cnt;
  logic [3:0]  cnt_nxt;
  logic        ack_entry;
  logic        in_window;
  logic [3:0]  idx;
  logic [15:0] acc_cnt;
  logic [15:0] reg_file [16];

  // Byte-lane merge: each active-low strobe replaces its half of the word.
  function automatic logic [15:0] merge_lanes(input logic [15:0] old_word,
                                              input logic [15:0] new_word,
                                              input logic        uds_n,
                                              input logic        lds_n);
    logic [15:0] w;
    w = old_word;
    if (!uds_n) w[15:8] = new_word[15:8];
    if (!lds_n) w[7:0]  = new_word[7:0];
    return w;
  endfunction

  // Read mux: index 15 returns the access counter, not storage.
  function automatic logic [15:0] read_word(input logic [3:0]  sel_idx,
                                            input logic [15:0] cnt_val,
                                            input logic [15:0] stored);
    return (sel_idx == CNT_IDX) ? cnt_val : stored;
  endfunction

  assign in_window = (M68K_ADDR[23:5] == BASE_ADDR[23:5]);
  assign idx       = M68K_ADDR[4:1];

  // Bus cycle sequencing: decode, wait-state countdown, acknowledge, release.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ack_entry = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!nAS) begin
          if (in_window) begin
            state_nxt = ST_WAIT;
            cnt_nxt   = WAIT_INIT;
          end else begin
            state_nxt = ST_IGNORE;
          end
        end
      end
      ST_IGNORE: begin
        if (nAS) state_nxt = ST_IDLE;
      end
      ST_WAIT: begin
        if (nAS) begin
          // Strobe withdrawn before acknowledge: abandon the cycle.
          state_nxt = ST_IDLE;
          cnt_nxt   = 4'd0;
        end else if (cnt == 4'd0) begin
          state_nxt = ST_ACK;
          ack_entry = 1'b1;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      ST_ACK: begin
        if (nAS) state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = 4'd0;
      end
    endcase
  end

  // State and wait counter registers.
  always_ff @(posedge CLK_68KCLK) begin
    if (!nRESET) begin
      state <= ST_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Registered bus outputs: assert on ACK entry, drop on the release edge.
  always_ff @(posedge CLK_68KCLK) begin
    if (!nRESET) begin
      nDTACK        <= 1'b1;
      DATA_OE       <= 1'b0;
      M68K_DATA_OUT <= 16'h0000;
    end else if (ack_entry) begin
      nDTACK <= 1'b0;
      if (M68K_RW) begin
        DATA_OE       <= 1'b1;
        M68K_DATA_OUT <= read_word(idx, acc_cnt, reg_file[idx]);
      end else begin
        DATA_OE <= 1'b0;
      end
    end else if (state == ST_ACK && nAS) begin
      nDTACK  <= 1'b1;
      DATA_OE <= 1'b0;
    end
  end

  // Register file: writes commit on the ACK-entry edge; index 15 is never stored.
  always_ff @(posedge CLK_68KCLK) begin
    if (!nRESET) begin
      for (int i = 0; i < 16; i++) reg_file[i] <= 16'h0000;
    end else if (ack_entry && !M68K_RW && idx != CNT_IDX) begin
      reg_file[idx] <= merge_lanes(reg_file[idx], M68K_DATA_IN, nUDS, nLDS);
    end
  end

  // Access counter: one count per acknowledged cycle, wrapping at 16 bits.
  always_ff @(posedge CLK_68KCLK) begin
    if (!nRESET) begin
      acc_cnt <= 16'h0000;
    end else begin
      acc_cnt <= acc_cnt + {15'd0, ack_entry};
    end
  end

endmodule

// File: tb/tb_m68k_reg_responder.sv
// Bench for m68k_reg_responder: table of bus cycles with hand-derived
// expectations, scoreboard queue, and hand sequences for abort, counter
// wrap and reset during acknowledge.
module tb_m68k_reg_responder;

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic [23:1] addr = '0;
  logic [15:0] din = '0;
  logic        rw = 1'b1;
  logic        uds_n = 1'b1;
  logic        lds_n = 1'b1;
  logic        nas = 1'b1;
  logic        sel5 = 1'b0;

  logic        nas_a, nas_b;
  logic [15:0] dout_a, dout_b;
  logic        oe_a, oe_b, dtack_a, dtack_b;
  logic [15:0] obs_dout;
  logic        obs_oe, obs_dtack;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [23:0] baddr;
    logic [15:0] wd;
    logic        rw;
    logic        uds;
    logic        lds;
    logic        ack;
    logic [15:0] rd;
  } vec_t;

  typedef struct {
    logic        ack;
    logic        rd;
    logic [15:0] rdata;
    int          lat;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[16];

  assign nas_a     = sel5 ? 1'b1 : nas;
  assign nas_b     = sel5 ? nas : 1'b1;
  assign obs_dout  = sel5 ? dout_b : dout_a;
  assign obs_oe    = sel5 ? oe_b : oe_a;
  assign obs_dtack = sel5 ? dtack_b : dtack_a;

  always #5 clk = ~clk;

  m68k_reg_responder #(.BASE_ADDR(24'h3C0000), .WAIT_STATES(1)) dut1 (
    .CLK_68KCLK(clk), .nRESET(nreset), .M68K_ADDR(addr), .M68K_DATA_IN(din),
    .M68K_DATA_OUT(dout_a), .DATA_OE(oe_a), .nAS(nas_a), .nUDS(uds_n),
    .nLDS(lds_n), .M68K_RW(rw), .nDTACK(dtack_a)
  );

  m68k_reg_responder #(.BASE_ADDR(24'h3C0000), .WAIT_STATES(5)) dut5 (
    .CLK_68KCLK(clk), .nRESET(nreset), .M68K_ADDR(addr), .M68K_DATA_IN(din),
    .M68K_DATA_OUT(dout_b), .DATA_OE(oe_b), .nAS(nas_b), .nUDS(uds_n),
    .nLDS(lds_n), .M68K_RW(rw), .nDTACK(dtack_b)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One complete bus cycle; the expectation is queued before the cycle is driven.
  task automatic do_access(input string nm, input logic [23:0] baddr, input logic [15:0] wd,
                           input logic r, input logic u, input logic l,
                           input logic exp_ack, input logic [15:0] exp_rd);
    exp_t e;
    int   edges;
    logic got_ack;
    logic bad_idle;
    sb.push_back('{exp_ack, r, exp_rd, sel5 ? 6 : 2});
    addr  = baddr[23:1];
    din   = wd;
    rw    = r;
    uds_n = u;
    lds_n = l;
    nas   = 1'b0;
    edges = 0;
    got_ack  = 1'b0;
    bad_idle = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      edges++;
      if (obs_oe) bad_idle = 1'b1;
      if (!obs_dtack) begin
        got_ack = 1'b1;
        break;
      end
      if (!exp_ack && edges >= 10) break;
    end
    e = sb.pop_front();
    chk({nm, "_ack"}, {31'd0, got_ack}, {31'd0, e.ack});
    if (e.ack && got_ack) begin
      chk({nm, "_lat"}, edges - 1, e.lat);
      chk({nm, "_oe"}, {31'd0, obs_oe}, {31'd0, e.rd});
      if (e.rd) chk({nm, "_data"}, {16'd0, obs_dout}, {16'd0, e.rdata});
    end else if (!e.ack) begin
      chk({nm, "_idle_oe"}, {31'd0, bad_idle}, 32'd0);
    end
    nas   = 1'b1;
    uds_n = 1'b1;
    lds_n = 1'b1;
    @(posedge clk); #1;
    chk({nm, "_rel"}, {30'd0, obs_dtack, obs_oe}, {30'd0, 1'b1, 1'b0});
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{24'h3C0004, 16'hBEEF, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000};
    tbl[1]  = '{24'h3C0004, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 16'hBEEF};
    tbl[2]  = '{24'h3C001E, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0002};
    tbl[3]  = '{24'h3C0006, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000};
    tbl[4]  = '{24'h3C0006, 16'hAA55, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000};
    tbl[5]  = '{24'h3C0006, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 16'hAA34};
    tbl[6]  = '{24'h3C0006, 16'hAA55, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000};
    tbl[7]  = '{24'h3C0006, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 16'hAA55};
    tbl[8]  = '{24'h3D0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000};
    tbl[9]  = '{24'h3BFFFE, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};
    tbl[10] = '{24'h3C0006, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 16'hAA55};
    tbl[11] = '{24'h3C001E, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0009};
    tbl[12] = '{24'h3C0004, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0000};
    tbl[13] = '{24'h3C0004, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 16'hBEEF};
    tbl[14] = '{24'h3C001E, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000};
    tbl[15] = '{24'h3C001E, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 16'h000D};

    // Reset state of both instances
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dtack_a", {31'd0, dtack_a}, 32'd1);
    chk("rst_oe_a", {31'd0, oe_a}, 32'd0);
    chk("rst_dout_a", {16'd0, dout_a}, 32'd0);
    chk("rst_dtack_b", {31'd0, dtack_b}, 32'd1);
    chk("rst_oe_b", {31'd0, oe_b}, 32'd0);
    chk("rst_dout_b", {16'd0, dout_b}, 32'd0);
    nreset = 1'b1;
    @(posedge clk); #1;

    // Table of bus cycles on the one-wait-state instance
    for (int i = 0; i < 16; i++) begin
      do_access($sformatf("vec%0d", i), tbl[i].baddr, tbl[i].wd, tbl[i].rw,
                tbl[i].uds, tbl[i].lds, tbl[i].ack, tbl[i].rd);
    end

    // Abort during wait states on the five-wait-state instance
    sel5  = 1'b1;
    addr  = 23'(24'h3C0004 >> 1);
    din   = 16'h1234;
    rw    = 1'b0;
    uds_n = 1'b0;
    lds_n = 1'b0;
    nas   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk($sformatf("abort_wait%0d", i), {31'd0, dtack_b}, 32'd1);
    end
    nas   = 1'b1;
    uds_n = 1'b1;
    lds_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk($sformatf("abort_after%0d", i), {30'd0, dtack_b, oe_b}, {30'd0, 1'b1, 1'b0});
    end
    do_access("cnt_wr15", 24'h3C001E, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
    do_access("cnt_rd15", 24'h3C001E, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0001);
    do_access("abort_rd2", 24'h3C0004, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0000);
    sel5 = 1'b0;

    // Reset while acknowledging a read
    addr = 23'(24'h3C0004 >> 1);
    rw   = 1'b1;
    nas  = 1'b0;
    begin
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
        @(posedge clk); #1;
        if (!dtack_a) begin
          seen = 1'b1;
          break;
        end
      end
      chk("rstack_ack", {31'd0, seen}, 32'd1);
      chk("rstack_data", {16'd0, dout_a}, {16'd0, 16'hBEEF});
    end
    nreset = 1'b0;
    @(posedge clk); #1;
    chk("rstack_dtack", {31'd0, dtack_a}, 32'd1);
    chk("rstack_oe", {31'd0, oe_a}, 32'd0);
    chk("rstack_dout", {16'd0, dout_a}, 32'd0);
    nreset = 1'b1;
    nas    = 1'b1;
    @(posedge clk); #1;
    do_access("clr_rd15", 24'h3C001E, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0000);
    for (int i = 0; i < 15; i++) begin
      do_access($sformatf("clr_rd%0d", i), 24'h3C0000 + 24'(i * 2), 16'h0000,
                1'b1, 1'b0, 1'b0, 1'b1, 16'h0000);
    end

    // Counter wrap from 16'hFFFF
    force dut1.acc_cnt = 16'hFFFF;
    @(posedge clk); #1;
    release dut1.acc_cnt;
    @(posedge clk); #1;
    do_access("wrap_wr0", 24'h3C0000, 16'h5A5A, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
    do_access("wrap_rd15", 24'h3C001E, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0000);
    do_access("wrap_rd0", 24'h3C0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 16'h5A5A);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/m68k_reg_responder.md
# m68k_reg_responder

Bus responder for the 68k side of the system: decodes a 68k bus cycle addressed to its window, inserts a fixed number of wait states, then answers with nDTACK, returning read data or committing byte-lane writes to a 16 x 16-bit register file. It is the slave counterpart to the 68k CPU wrapper and sits directly on the CPU address, data and strobe lines, alongside other decoded devices (WRAM, BIOS, I/O).

## Interface
- BASE_ADDR, 24'h3C0000: byte base of the window; only bits [23:5] are compared.
- WAIT_STATES, 1: clocks inserted between decode and nDTACK assertion, range 0..15.
- CLK_68KCLK  in  1  sole clock; all logic on its rising edge.
- nRESET  in  1  reset, synchronous and active-low.
- M68K_ADDR  in  23  word address [23:1]; [4:1] selects the register.
- M68K_DATA_IN  in  16  write data from the CPU.
- M68K_DATA_OUT  out  16  read data to the CPU, registered.
- DATA_OE  out  1  high while this block drives M68K_DATA_OUT onto the bus.
- nAS  in  1  address strobe, active-low.
- nUDS, nLDS  in  1 each  upper (15:8) and lower (7:0) data strobes, active-low.
- M68K_RW  in  1  1 = read, 0 = write.
- nDTACK  out  1  data acknowledge, active-low, registered.

## Operation
- Select is `nAS==0` and `M68K_ADDR[23:5]==BASE_ADDR[23:5]`.
- Register file: REG[0..14] are read/write. REG[15] is a read-only access counter.
- REG[15] increments by 1, mod 2^16, on every ACK entry (reads and writes, including a write to index 15).
- Writes to REG[15] change nothing except the increment.
- States:
  - IDLE: nDTACK=1, DATA_OE=0.
    - nAS==0 and selected → WAIT, cnt←WAIT_STATES.
    - nAS==0 and not selected → IGNORE.
  - IGNORE: stays until nAS==1, then → IDLE. Outputs stay idle.
  - WAIT:
    - nAS==1 → IDLE. Aborted: no write, no count.
    - cnt==0 → ACK.
    - otherwise cnt←cnt-1.
  - ACK: nDTACK=0.
    - Read: M68K_DATA_OUT=REG[idx], full word regardless of strobes, DATA_OE=1.
    - Stays until nAS==1, then → IDLE with nDTACK=1, DATA_OE=0.
- Register index, RW and strobes are sampled on the edge that enters ACK.
- Write commit happens on that same edge, per lane:
  - nUDS==0 → bits 15:8 written.
  - nLDS==0 → bits 7:0 written.
  - Both strobes high → no write, but ACK and count still occur.
- Address or RW changes while in ACK are ignored; the cycle is already committed.
- Reset:
  - Any state → IDLE.
  - nDTACK=1, DATA_OE=0, M68K_DATA_OUT=16'h0000, cnt=0.
  - All 16 registers = 16'h0000.
  - Reset mid-cycle drops any pending write.

## Timing
- Edge e0 samples nAS low and selected.
- With WAIT_STATES=N, nDTACK goes low after edge e(N+1) (N=0 → one clock after decode).
- Read data and DATA_OE become valid on the same edge nDTACK falls.
- Release: the first edge sampling nAS==1 in ACK deasserts nDTACK and DATA_OE on that edge.
- nDTACK never low while nAS is sampled high, except the single clock in which the rising nAS is first observed.
- Back-to-back: IDLE accepts a new cycle on the first edge after release.
- A new nAS low seen on the release edge is not decoded until the next edge.

## Test plan
- Word write then read, WAIT_STATES=1:
  - Write 16'hBEEF to 0x3C0004, then read 0x3C0004.
  - nDTACK low 2 clocks after decode on each access.
  - Read returns 16'hBEEF with DATA_OE=1.
  - REG[15] = 2.
- Byte lanes:
  - Preload REG[3]=16'h1234.
  - Write 16'hAA55 with nUDS=0, nLDS=1 → REG[3]=16'hAA34.
  - Write 16'hAA55 with nUDS=1, nLDS=0 → REG[3]=16'hAA55.
- Out of window:
  - Access 0x3D0000 and 0x3BFFFE.
  - nDTACK stays 1 and DATA_OE stays 0 throughout.
  - No register changes; REG[15] unchanged.
- Abort: nAS rises during WAIT with WAIT_STATES=5 → no write, no count, nDTACK never asserted, back in IDLE.
- Counter:
  - Write 16'h0000 to index 15 → reads back 16'h0001 on the next access.
  - Preload count 16'hFFFF; one access wraps it to 16'h0000.
- Reset mid-ACK: nRESET low during ACK → next edge nDTACK=1, DATA_OE=0, all registers read 16'h0000 after release.
